// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and helpers for the APB memory slave.
//             - apb_state_e : transfer FSM encoding (2-bit)
//             - WAIT_W      : width of the wait-state counter
//             - lane_count  : byte lanes for a given data width
//             - idx_width   : word-index width for a byte address bus
//  Revision : 1.0  initial release
// ============================================================================
package apb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // Byte address minus the in-word byte-offset bits.
  function automatic int idx_width(input int addr_width, input int data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_sram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : apb_sram_bank
//  Purpose  : DEPTH x DATA_WIDTH storage, byte-enabled synchronous write,
//             synchronous read with one cycle of latency. No reset.
//  Ports    : clk       - clock
//             i_we      - write enable (lanes gated by i_strb)
//             i_re      - read enable; read register loads zero when low
//             i_addr    - word index
//             i_wdata   - write data
//             i_strb    - byte-lane write enables
//             o_rdata   - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module apb_sram_bank
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 48,
  parameter int ADDR_W     = 6
) (
  input  logic                             clk,
  input  logic                             i_we,
  input  logic                             i_re,
  input  logic [ADDR_W-1:0]                i_addr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [lane_count(DATA_WIDTH)-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam int STRB_W = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // The read register doubles as the slave's PRDATA flop: it holds zero on
  // every cycle that is not a successful read, so no extra output mux is
  // needed after it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (i_strb[i]) begin
          mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    rdata_q <= i_re ? mem[i_addr] : '0;
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave
//  Purpose  : APB4 memory-mapped slave with programmable wait states, byte
//             strobes and PSLVERR on out-of-range or misaligned addresses.
//  Ports    : PCLK/PRESETn        - clock, synchronous active-low reset
//             PSEL/PENABLE/PWRITE - APB control
//             PADDR/PWDATA/PSTRB  - byte address, write data, lane enables
//             PRDATA/PREADY/PSLVERR - registered completion outputs
//  Revision : 1.0  initial release
// ============================================================================
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 48,
  parameter int WAIT_STATES = 1
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [ADDR_WIDTH-1:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]             PWDATA,
  input  logic [lane_count(DATA_WIDTH)-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR
);

  localparam int STRB_W    = lane_count(DATA_WIDTH);
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = idx_width(ADDR_WIDTH, DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << LANE_BITS) - 1);
  localparam logic [IDX_W:0]        DEPTH_C  = (IDX_W+1)'(DEPTH);
  localparam logic [WAIT_W-1:0]     WAIT_C   = WAIT_W'(WAIT_STATES);

  apb_state_e              state_q,   state_d;
  logic [WAIT_W-1:0]       cnt_q,     cnt_d;
  logic [IDX_W-1:0]        idx_q,     idx_d;
  logic                    write_q,   write_d;
  logic                    err_q,     err_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [STRB_W-1:0]       strb_q,    strb_d;
  logic                    pready_q,  pready_d;
  logic                    pslverr_q, pslverr_d;

  logic                    setup;
  logic [IDX_W-1:0]        req_idx;
  logic                    req_err;
  logic                    mem_we;
  logic                    mem_re;
  logic [IDX_W-1:0]        mem_addr;

  assign setup   = PSEL && !PENABLE;
  assign req_idx = PADDR[ADDR_WIDTH-1 -: IDX_W];
  assign req_err = ({1'b0, req_idx} >= DEPTH_C) || ((PADDR & OFS_MASK) != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = idx_q;

    case (state_q)
      IDLE: begin
        // The SRAM read is issued from the live bus address so a zero-wait
        // build still has PRDATA ready in the first access cycle.
        mem_addr = req_idx;
        if (setup) begin
          idx_d   = req_idx;
          write_d = PWRITE;
          err_d   = req_err;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = WAIT_C;
          if (WAIT_STATES == 0) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = req_err;
            mem_re    = !PWRITE && !req_err;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q <= WAIT_W'(1)) begin
          // Last wait cycle: everything that becomes visible with PREADY
          // is loaded at this edge.
          state_d   = DONE;
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          mem_re    = !write_q && !err_q;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end

      DONE: begin
        mem_we  = PSEL && PENABLE && write_q && !err_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset edge must neither commit a pending write nor load read data.
    if (!PRESETn) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Transfer attributes are only consumed after a setup cycle reloads them.
  always_ff @(posedge PCLK) begin
    idx_q   <= idx_d;
    write_q <= write_d;
    err_q   <= err_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

  apb_sram_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (IDX_W)
  ) u_bank (
    .clk     (PCLK),
    .i_we    (mem_we),
    .i_re    (mem_re),
    .i_addr  (mem_addr),
    .i_wdata (wdata_q),
    .i_strb  (strb_q),
    .o_rdata (PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mem_slave
//  Purpose  : Self-checking bench for apb_mem_slave. Three slaves with 0, 1
//             and 3 wait states share the bus, each with its own PSEL, and
//             each is compared against a word-array model of its memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_mem_slave;

  logic        clk;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int          checks;
  int          failures;
  int          ws [3];
  logic [31:0] mdl [3][48];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer on slave w. Expectations come from the address
  // rules and the word model; the model is updated only for committed writes.
  task automatic xfer(input int w, input bit wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input bit rst_in_done, output logic [31:0] rd);
    int          n;
    int          idx;
    bit          err;
    logic [31:0] exp_rd;
    idx    = int'(addr) / 4;
    err    = (addr % 4 != 0) || (idx >= 48);
    exp_rd = (wr || err) ? 32'h0 : mdl[w][idx];

    @(posedge clk); #1;
    check($sformatf("idle_ready[%0d]", w), 64'(pready[w]), 64'h0);
    check($sformatf("idle_rdata[%0d]", w), 64'(prdata[w]), 64'h0);
    psel    = 3'b001 << w;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;

    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    while (!pready[w] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency[%0d]", w), 64'(n), 64'(ws[w] + 1));
    check($sformatf("slverr[%0d] a=%0h", w, addr), 64'(pslverr[w]), 64'(err));
    check($sformatf("rdata[%0d] a=%0h", w, addr), 64'(prdata[w]), 64'(exp_rd));
    rd = prdata[w];

    if (rst_in_done) begin
      presetn = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", 64'(pready[w]), 64'h0);
      check("rst_slverr", 64'(pslverr[w]), 64'h0);
      check("rst_rdata", 64'(prdata[w]), 64'h0);
      presetn = 1'b1;
      psel    = 3'b000;
      penable = 1'b0;
    end else if (wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[w][idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  // Setup cycle then PSEL dropped in the first access cycle.
  task automatic abort_write(input int w, input logic [7:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    psel    = 3'b001 << w;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = addr;
    pwdata  = data;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    for (int k = 0; k < ws[w] + 2; k++) begin
      check("abort_ready", 64'(pready[w]), 64'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  ra;
    int          rw;

    checks   = 0;
    failures = 0;
    ws[0] = 0;
    ws[1] = 1;
    ws[2] = 3;
    presetn = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 32'h0;
    pstrb   = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("reset_ready[%0d]", w), 64'(pready[w]), 64'h0);
      check($sformatf("reset_slverr[%0d]", w), 64'(pslverr[w]), 64'h0);
      check($sformatf("reset_rdata[%0d]", w), 64'(prdata[w]), 64'h0);
    end
    presetn = 1'b1;

    // Give every word a known value so all later reads have an expectation.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 48; i++) begin
        xfer(w, 1'b1, 8'(i * 4), $urandom, 4'hF, 1'b0, rd);
      end
    end
    go_idle();

    // Basic write/read on the default-latency slave.
    xfer(1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
    xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0, rd);
    check("basic_read", 64'(rd), 64'hDEADBEEF);

    // Partial-lane write.
    xfer(1, 1'b1, 8'h20, 32'h11223344, 4'hF, 1'b0, rd);
    xfer(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd);
    xfer(1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, rd);
    check("strobe_read", 64'(rd), 64'h11BB33DD);

    // Empty strobe changes nothing.
    xfer(1, 1'b1, 8'h20, 32'h00000000, 4'h0, 1'b0, rd);
    xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, 1'b0, rd);
    check("nostrb_read", 64'(rd), 64'h11BB33DD);

    // Out-of-range and misaligned accesses, then word 0 must be untouched.
    xfer(1, 1'b0, 8'hC0, 32'h0, 4'h0, 1'b0, rd);
    xfer(1, 1'b1, 8'h03, 32'h00000055, 4'hF, 1'b0, rd);
    xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, rd);
    go_idle();

    // Back-to-back write then read on the zero- and three-wait slaves.
    xfer(0, 1'b1, 8'h04, 32'hCAFEF00D, 4'hF, 1'b0, rd);
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, rd);
    check("b2b_ws0", 64'(rd), 64'hCAFEF00D);
    xfer(2, 1'b1, 8'h04, 32'h0BADC0DE, 4'hF, 1'b0, rd);
    xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, rd);
    check("b2b_ws3", 64'(rd), 64'h0BADC0DE);
    go_idle();

    // PENABLE high in IDLE without a setup cycle is ignored.
    @(posedge clk); #1;
    psel    = 3'b111;
    penable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("stray_enable", 64'(pready), 64'h0);
    end
    psel    = 3'b000;
    penable = 1'b0;

    // Abort during the wait of a write, then read back the old data.
    abort_write(1, 8'h08, 32'h12345678);
    abort_write(2, 8'h08, 32'h12345678);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, rd);
    xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, rd);
    go_idle();

    // Reset in the PREADY cycle of a write: nothing committed.
    xfer(1, 1'b1, 8'h0C, 32'hFFFF0000, 4'hF, 1'b1, rd);
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, rd);
    xfer(2, 1'b1, 8'h0C, 32'h0000FFFF, 4'hF, 1'b1, rd);
    xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, rd);
    go_idle();

    // Randomised traffic across all three slaves.
    for (int t = 0; t < 200; t++) begin
      rw = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ra = 8'($urandom);
      else                           ra = 8'($urandom_range(0, 47) * 4);
      xfer(rw, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b0, rd);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave and the next generation of the team's 8-bit APB slave. It is generalised in data/address width and depth, and adds a registered FSM, programmable wait states, byte strobes and PSLVERR. It sits on the APB bus behind the APB master/bridge and backs scratch RAM or register storage for peripherals.

Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA width. Must be a multiple of 8, range 8..64.
- ADDR_WIDTH, 8: PADDR width, in bytes.
- DEPTH, 48: number of DATA_WIDTH-bit words implemented. Must satisfy DEPTH <= 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).
- WAIT_STATES, 1: access-phase cycles with PREADY=0 before completion. Range 0..15.

Ports:
- PCLK, input, 1: clock. All logic on the rising edge.
- PRESETn, input, 1: reset, synchronous, active-low.
- PSEL, input, 1: slave select.
- PENABLE, input, 1: access-phase indicator.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH: byte address.
- PWDATA, input, DATA_WIDTH: write data.
- PSTRB, input, DATA_WIDTH/8: write byte-lane enables.
- PRDATA, output, DATA_WIDTH: read data.
- PREADY, output, 1: transfer complete.
- PSLVERR, output, 1: transfer error. Valid only while PREADY=1.

Behaviour:
- One clock, PCLK. Reset is synchronous, active-low, on PRESETn. Sampled on the rising edge of PCLK.
- Reset values: state IDLE, PREADY 0, PSLVERR 0, PRDATA 0, wait counter 0. Memory contents are not reset.
- All outputs are registered. There are no combinational input-to-output paths.
- Word index = PADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
- Address error: word index >= DEPTH, or nonzero PADDR byte-offset bits.

FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup cycle T0): latch address, PWRITE, PWDATA and PSTRB; compute error; load counter with WAIT_STATES; go to ACCESS.
  - If WAIT_STATES=0: set PREADY=1 for T1, and load PRDATA with mem[idx] (or 0 on error / on write).
- ACCESS:
  - While counter > 0: decrement; PREADY=0.
  - When the counter reaches 0: assert PREADY, PSLVERR=err and PRDATA for the next cycle.
  - PREADY is high exactly in cycle T1+WAIT_STATES.
- DONE (PREADY=1 cycle):
  - Write commits at the closing edge of this cycle, only if PSEL & PENABLE & PWRITE & !err.
  - Only lanes with PSTRB[i]=1 are updated; other lanes are unchanged.
  - PSTRB=0 writes nothing and is not an error.
  - Next state is IDLE. PREADY, PSLVERR and PRDATA return to 0 the following cycle.
- Back-to-back: a setup cycle arriving in the cycle after DONE is accepted from IDLE normally. A read of a just-written word returns the new data.
- Reads: PSTRB is ignored. An erroring read returns PRDATA=0 with PSLVERR=1.
- Errored writes do not modify memory.
- Abort: PSEL=0 while in ACCESS discards the transfer. Next state is IDLE with no write; PREADY stays 0.
- PENABLE=1 while in IDLE without a preceding setup cycle is ignored and the slave stays in IDLE.
- Reset during ACCESS or DONE: immediate return to IDLE with outputs at reset values. A write pending in that cycle is not committed.
- Latency: setup to PREADY = WAIT_STATES+1 cycles. Total transfer = WAIT_STATES+2 cycles.

Decomposition:
- Package apb_pkg contains:
  - typedef apb_state_e {IDLE, ACCESS, DONE};
  - constant functions for byte-lane count and word-index width;
  - localparam WAIT_W = 4.
- One sub-module, apb_sram_bank: DEPTH x DATA_WIDTH array with synchronous byte-enabled write and synchronous read (1-cycle registered read data), no reset.
- The FSM, wait counter and error decode stay in apb_mem_slave.

Test Plan:
- Defaults (DATA_WIDTH=32, DEPTH=48, WAIT_STATES=1): write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10 -> PREADY low in T1, high in T2; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte strobes: write 0x11223344 to 0x20 (PSTRB=F), then write 0xAABBCCDD with PSTRB=4'b0101, then read -> 0x11BB33DD.
- Errors: read 0xC0 (idx 48) -> PSLVERR=1, PRDATA=0. Write 0x55 to 0x03 (misaligned) -> PSLVERR=1. A subsequent read of 0x00 is unchanged.
- WAIT_STATES=0 and WAIT_STATES=3 builds: measure setup-to-PREADY -> 1 and 4 cycles. Back-to-back write then read of 0x04 returns the written data with no idle cycle.
- Abort and reset: drop PSEL during the wait of a write to 0x08 -> no PREADY, memory unchanged. Assert PRESETn=0 in the DONE cycle of a write -> PREADY=0 next cycle, write not committed.
